// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: detects a host start pulse on the shared line,
// answers with the response preamble and a 40-bit frame ending in a checksum.
module dht11_responder #(
    parameter int T_START_MIN = 18000,
    parameter int T_WAIT      = 30,
    parameter int T_RESP      = 80,
    parameter int T_BIT_LOW   = 50,
    parameter int T_ZERO      = 26,
    parameter int T_ONE       = 70
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_in,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       drive_low,
    output logic       busy,
    output logic       frame_done
);

    localparam int TSUM = T_START_MIN + T_WAIT + T_RESP + T_BIT_LOW + T_ZERO + T_ONE;
    localparam int CW   = $clog2(TSUM + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HOST_LOW, S_WAIT, S_RESP_LOW,
        S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [5:0]      bidx_q, bidx_d;
    logic [39:0]     shift_q, shift_d;
    logic            done_q, done_d;
    logic [CW-1:0]   lim;
    logic            phase_end;
    logic [7:0]      csum;
    logic            line_s;

    assign line_s    = sync2_q;
    assign csum      = hum_int + hum_dec + temp_int + temp_dec;
    assign phase_end = (cnt_q == lim - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= line_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    // Length of the current timed phase; the bit high phase depends on the MSB in flight.
    always_comb begin
        lim = CW'(1);
        case (state_q)
            S_WAIT:      lim = CW'(T_WAIT);
            S_RESP_LOW,
            S_RESP_HIGH: lim = CW'(T_RESP);
            S_BIT_LOW,
            S_END_LOW:   lim = CW'(T_BIT_LOW);
            S_BIT_HIGH:  lim = shift_q[39] ? CW'(T_ONE) : CW'(T_ZERO);
            default:     lim = CW'(1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!line_s) begin
                    state_d = S_HOST_LOW;
                    cnt_d   = '0;
                end
            end
            S_HOST_LOW: begin
                if (!line_s) begin
                    if (cnt_q != CW'(T_START_MIN)) cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d   = '0;
                    state_d = (cnt_q == CW'(T_START_MIN)) ? S_WAIT : S_IDLE;
                end
            end
            default: begin
                // Timed phases: line_in is deliberately ignored here.
                if (!phase_end) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    case (state_q)
                        S_WAIT: begin
                            state_d = S_RESP_LOW;
                            shift_d = {hum_int, hum_dec, temp_int, temp_dec, csum};
                            bidx_d  = 6'd39;
                        end
                        S_RESP_LOW:  state_d = S_RESP_HIGH;
                        S_RESP_HIGH: state_d = S_BIT_LOW;
                        S_BIT_LOW:   state_d = S_BIT_HIGH;
                        S_BIT_HIGH: begin
                            if (bidx_q == 6'd0) begin
                                state_d = S_END_LOW;
                            end else begin
                                state_d = S_BIT_LOW;
                                bidx_d  = bidx_q - 6'd1;
                                shift_d = {shift_q[38:0], 1'b0};
                            end
                        end
                        S_END_LOW: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        drive_low  = (state_q == S_RESP_LOW) || (state_q == S_BIT_LOW) || (state_q == S_END_LOW);
        busy       = (state_q == S_RESP_LOW) || (state_q == S_RESP_HIGH) || (state_q == S_BIT_LOW)
                  || (state_q == S_BIT_HIGH) || (state_q == S_END_LOW);
        frame_done = done_q;
    end

endmodule

// File: tb/tb_dht11_responder.sv
// Directed bench for dht11_responder: decodes the drive_low waveform into
// phase lengths and bits and compares against hand-computed frames.
module tb_dht11_responder;

    localparam int T_START_MIN = 20;
    localparam int T_WAIT      = 3;
    localparam int T_RESP      = 8;
    localparam int T_BIT_LOW   = 5;
    localparam int T_ZERO      = 3;
    localparam int T_ONE       = 7;
    localparam int MAXW        = 3000;

    logic       clk = 1'b0;
    logic       rst;
    logic       line_in;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
    logic       drive_low, busy, frame_done;

    int checks = 0;
    int errors = 0;

    dht11_responder #(
        .T_START_MIN(T_START_MIN), .T_WAIT(T_WAIT), .T_RESP(T_RESP),
        .T_BIT_LOW(T_BIT_LOW), .T_ZERO(T_ZERO), .T_ONE(T_ONE)
    ) dut (
        .clk(clk), .rst(rst), .line_in(line_in),
        .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
        .drive_low(drive_low), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [7:0] a, b, c, d);
        hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
    endtask

    // Host holds the line low for n sampled ticks, then releases it.
    task automatic host_low(input int n);
        @(posedge clk); #1 line_in = 1'b0;
        repeat (n) @(posedge clk);
        #1 line_in = 1'b1;
    endtask

    task automatic monitor(input int n, output int dl, output int bz, output int fd);
        dl = 0; bz = 0; fd = 0;
        repeat (n) begin
            @(negedge clk);
            if (drive_low !== 1'b0) dl++;
            if (busy !== 1'b0) bz++;
            if (frame_done !== 1'b0) fd++;
        end
    endtask

    task automatic wait_falls(input int n, output bit ok);
        int seen = 0;
        int t = 0;
        logic prev;
        prev = drive_low;
        while (seen < n && t < MAXW) begin
            @(negedge clk); t++;
            if (prev === 1'b1 && drive_low === 1'b0) seen++;
            prev = drive_low;
        end
        ok = (seen == n);
    endtask

    // Captures one frame as a list of alternating driven/released run lengths.
    task automatic run_frame(input string tag, input logic [39:0] exp_frame);
        int run [0:127];
        int nrun = 0, len = 0, t = 0, busy_bad = 0, bad_lo = 0, bad_hi = 0;
        int dl, bz, fd;
        logic cur;
        bit done = 0;
        logic [39:0] frame = '0;
        while (drive_low !== 1'b1 && t < MAXW) begin @(negedge clk); t++; end
        cur = 1'b1;
        while (!done && t < MAXW) begin
            if (frame_done === 1'b1) begin
                done = 1;
                if (busy !== 1'b0) busy_bad++;
                if (nrun < 128) run[nrun] = len;
                nrun++;
            end else begin
                if (busy !== 1'b1) busy_bad++;
                if (drive_low === cur) len++;
                else begin
                    if (nrun < 128) run[nrun] = len;
                    nrun++;
                    cur = drive_low;
                    len = 1;
                end
                @(negedge clk); t++;
            end
        end
        chk({tag, "_timeout"}, done, 1'b1);
        chk({tag, "_nrun"}, nrun, 83);
        if (nrun == 83) begin
            for (int i = 0; i < 40; i++) begin
                if (run[2 + 2*i] != T_BIT_LOW) bad_lo++;
                if (run[3 + 2*i] != T_ZERO && run[3 + 2*i] != T_ONE) bad_hi++;
                frame = {frame[38:0], run[3 + 2*i] == T_ONE};
            end
            chk({tag, "_resp_lo"}, run[0], T_RESP);
            chk({tag, "_resp_hi"}, run[1], T_RESP);
            chk({tag, "_bit_lo"}, bad_lo, 0);
            chk({tag, "_bit_hi"}, bad_hi, 0);
            chk({tag, "_frame"}, frame, exp_frame);
            chk({tag, "_end_lo"}, run[82], T_BIT_LOW);
        end
        chk({tag, "_busy"}, busy_bad, 0);
        monitor(40, dl, bz, fd);
        chk({tag, "_post_fd"}, fd, 0);
        chk({tag, "_post_dl"}, dl, 0);
    endtask

    initial begin
        int dl, bz, fd, t;
        bit ok;
        rst = 1'b1;
        line_in = 1'b1;
        set_data(8'h00, 8'h00, 8'h00, 8'h00);
        #22;
        chk("rst_drive", drive_low, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(posedge clk);

        // Nominal frame: checksum 0x37+0x19 = 0x50.
        set_data(8'h37, 8'h00, 8'h19, 8'h00);
        host_low(25);
        run_frame("frameA", 40'h37_00_19_00_50);

        // Short host pulse must be ignored.
        host_low(10);
        monitor(80, dl, bz, fd);
        chk("short_dl", dl, 0);
        chk("short_busy", bz, 0);
        chk("short_fd", fd, 0);

        // All ones: checksum wraps to 0xFC.
        set_data(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        host_low(25);
        run_frame("frameB", 40'hFF_FF_FF_FF_FC);

        // Inputs change during RESP_HIGH and host pulls line low mid-frame.
        set_data(8'h12, 8'h34, 8'h56, 8'h78);
        host_low(25);
        fork
            run_frame("frameC", 40'h12_34_56_78_14);
            begin
                repeat (17) @(posedge clk);
                #1 set_data(8'h00, 8'h00, 8'h00, 8'h00);
                wait_falls(6, ok);
                line_in = 1'b0;
                repeat (2) @(posedge clk);
                #1 line_in = 1'b1;
            end
        join

        // Reset during BIT_HIGH of bit 20.
        set_data(8'h37, 8'h00, 8'h19, 8'h00);
        host_low(25);
        wait_falls(21, ok);
        chk("rst20_reached", ok, 1'b1);
        chk("rst20_busy_before", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("rst20_drive", drive_low, 1'b0);
        chk("rst20_busy", busy, 1'b0);
        chk("rst20_done", frame_done, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        monitor(100, dl, bz, fd);
        chk("rst20_post_fd", fd, 0);
        chk("rst20_post_dl", dl, 0);

        // Reset during the response low phase releases the line at once.
        host_low(25);
        t = 0;
        while (drive_low !== 1'b1 && t < MAXW) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        chk("rstlo_drive_before", drive_low, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstlo_drive", drive_low, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        monitor(20, dl, bz, fd);
        chk("rstlo_post_fd", fd, 0);

        // A fresh start after reset gives a complete frame.
        host_low(25);
        run_frame("frameD", 40'h37_00_19_00_50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dht11_responder.md
DHT11_RESPONDER -- requirements
Module: dht11_responder

Interface
REQ-001 Parameter T_START_MIN, default 18000, minimum host low time in clk ticks (1 us per tick) that counts as a valid start.
REQ-002 Parameter T_WAIT, default 30, ticks after host release before the response begins.
REQ-003 Parameter T_RESP, default 80, duration of the response low phase and of the response high phase.
REQ-004 Parameter T_BIT_LOW, default 50, low phase that precedes every data bit and the end marker.
REQ-005 Parameter T_ZERO, default 26, high duration encoding a 0.
REQ-006 Parameter T_ONE, default 70, high duration encoding a 1.
REQ-007 clk  input  1  single clock, 1 MHz tick in synthesis.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 line_in  input  1  sampled level of the shared data line.
REQ-010 hum_int, hum_dec, temp_int, temp_dec  input  8 each  measurement bytes to transmit.
REQ-011 drive_low  output  1  1 = pull line low (open-drain enable); 0 = release.
REQ-012 busy  output  1  high from the first tick of the response low phase to the end of the end marker.
REQ-013 frame_done  output  1  one-cycle pulse after the end marker completes.

Function
REQ-014 line_in shall pass through a 2-flop synchronizer, and all timing shall be measured on the synchronized level (2-cycle input latency).
REQ-015 States: IDLE, HOST_LOW, WAIT, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW.
REQ-016 IDLE: a synchronized low shall move the FSM to HOST_LOW and clear the tick counter.
REQ-017 HOST_LOW: the counter shall increment each tick while the line is low and saturate at T_START_MIN.
REQ-018 HOST_LOW on line high: counter == T_START_MIN -> WAIT; otherwise (short pulse) -> IDLE with no response.
REQ-019 WAIT: after T_WAIT ticks -> RESP_LOW, regardless of line level.
REQ-020 On entry to RESP_LOW, the 40-bit frame shall be latched: {hum_int, hum_dec, temp_int, temp_dec, checksum}. Checksum = (hum_int + hum_dec + temp_int + temp_dec) mod 256, 8-bit wrap.
REQ-021 Inputs changing after the latch shall not affect the frame in flight.
REQ-022 RESP_LOW: drive_low=1 for T_RESP ticks, then RESP_HIGH.
REQ-023 RESP_HIGH: drive_low=0 for T_RESP ticks, then BIT_LOW.
REQ-024 BIT_LOW: drive_low=1 for T_BIT_LOW ticks, then BIT_HIGH.
REQ-025 BIT_HIGH: drive_low=0 for T_ONE ticks if the current bit is 1, else T_ZERO ticks.
REQ-026 Bits shall be sent MSB first; bit index counts 39 down to 0.
REQ-027 After BIT_HIGH: if bit index is 0 -> END_LOW, else decrement the index and go to BIT_LOW.
REQ-028 END_LOW: drive_low=1 for T_BIT_LOW ticks, then IDLE with drive_low=0 and frame_done=1 for one cycle.
REQ-029 line_in shall be ignored from WAIT through END_LOW, including low levels while releasing the line; a new start is recognized only from IDLE.
REQ-030 Each phase duration shall be exact: the drive_low level is held for precisely N clk cycles.
REQ-031 busy shall equal 1 in RESP_LOW through END_LOW, and 0 otherwise.

Reset
REQ-032 rst high shall immediately force: state IDLE, drive_low=0, busy=0, frame_done=0, counters and shift register 0, synchronizer flops 1 (idle-high line).
REQ-033 Reset asserted mid-frame shall release the line at once, and no frame_done pulse shall follow.

Verification
REQ-034 Sim params (T_START_MIN=20, T_WAIT=3, T_RESP=8, T_BIT_LOW=5, T_ZERO=3, T_ONE=7) with inputs 0x37,0x00,0x19,0x00 and line low 25 ticks then high -> response 8 low/8 high, then 40 bits with checksum 0x50, end marker, frame_done once.
REQ-035 Host low for 10 ticks -> drive_low stays 0, busy stays 0, FSM back in IDLE.
REQ-036 Inputs 0xFF,0xFF,0xFF,0xFF -> checksum 0xFC (wrap); all data bits use a 7-tick high phase, and checksum bits 1-0 use 3-tick high phases.
REQ-037 Change the inputs during RESP_HIGH -> transmitted frame still carries the values latched at RESP_LOW entry.
REQ-038 Assert rst during BIT_HIGH of bit 20 -> drive_low=0 the same cycle, no frame_done; a subsequent valid start yields a complete correct frame.
REQ-039 Force line_in low during a BIT_HIGH phase -> frame timing unchanged, and no restart occurs.
